// File: rtl/serial_add_sub.sv
// Digit-serial adder/subtractor: DIGIT bits per clock through a registered-carry slice,
// with valid/ready handshakes on the operand and result sides.
module serial_add_sub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [DIGIT:0]   digit_sum;
  logic             msb_carry_in;
  logic             last_digit;
  logic             accept;

  assign in_ready   = (state == IDLE) || ((state == DONE) && out_ready);
  assign out_valid  = (state == DONE);
  assign accept     = in_valid && in_ready;
  assign last_digit = (cnt == CW'(N - 1));

  assign digit_sum = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]}
                   + {{DIGIT{1'b0}}, carry};

  // Result digits enter at the MSB end so after N shifts the LSB digit lands at bit 0.
  assign res_next = (res >> DIGIT) | (WIDTH'(digit_sum[DIGIT-1:0]) << (WIDTH - DIGIT));

  // Sum bit = a ^ b ^ carry_in, so the carry into the top bit of the digit falls out by XOR.
  assign msb_carry_in = a_sh[DIGIT-1] ^ b_sh[DIGIT-1] ^ digit_sum[DIGIT-1];

  // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (in_valid) state_next = RUN;
      RUN:     if (last_digit) state_next = DONE;
      DONE:    if (out_ready) state_next = in_valid ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: the shift/carry/counter registers carry no reset; they are always loaded on
  // acceptance before anything reads them, so only control and visible outputs are reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_sh  <= a;
      b_sh  <= sub ? ~b : b;
      carry <= cin ^ sub;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sh  <= a_sh >> DIGIT;
      b_sh  <= b_sh >> DIGIT;
      carry <= digit_sum[DIGIT];
      res   <= res_next;
      cnt   <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum  <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
    end else if ((state == RUN) && last_digit) begin
      sum  <= res_next;
      cout <= digit_sum[DIGIT];
      ovf  <= msb_carry_in ^ digit_sum[DIGIT];
    end
  end

endmodule
